// File: rtl/vc_pkg.sv
// Shared constants for the VC buffer read path: scheduler FSM encoding and VC/credit sizing.
package vc_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam int BUF_BITS_DEF    = 1;
    localparam int CREDIT_BITS_DEF = 3;
    localparam int MAX_CREDITS_DEF = 4;

    function automatic int num_vc(input int buf_bits);
        return 1 << buf_bits;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of the first requester after last_i, wrapping; purely combinational.
// Latency 0; no backpressure (a pure function of req_i and last_i).
module rr_arbiter #(
    parameter int NUM_VC = 2,
    parameter int IDX_W  = $clog2(NUM_VC)
) (
    input  logic [NUM_VC-1:0] req_i,
    input  logic [IDX_W-1:0]  last_i,
    output logic [NUM_VC-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]  gnt_idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NUM_VC is a power of two, so index arithmetic wraps for free.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        cand      = '0;
        found     = 1'b0;
        for (int i = 1; i <= NUM_VC; i++) begin
            cand = last_i + IDX_W'(i);
            if (req_i[cand] && !found) begin
                found           = 1'b1;
                gnt_oh_o[cand]  = 1'b1;
                gnt_idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/vc_read_scheduler.sv
// Read-side scheduler for one buffer_port: round-robin over credited non-empty VCs, one read in flight.
// Latency: grant -> bp_rdEn next cycle -> out_valid one cycle after the matching response; stalls on zero credit.
module vc_read_scheduler
    import vc_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BUF_BITS     = BUF_BITS_DEF,
    parameter int CREDIT_BITS  = CREDIT_BITS_DEF,
    parameter int MAX_CREDITS  = MAX_CREDITS_DEF,
    parameter int TIMEOUT_BITS = 4,
    localparam int NUM_VC      = num_vc(BUF_BITS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_VC-1:0]     bp_empty,
    output logic                  bp_rdEn,
    output logic [BUF_BITS-1:0]   bp_read_vc,
    input  logic                  bp_valid,
    input  logic [BUF_BITS-1:0]   bp_out_vc,
    input  logic [DATA_WIDTH-1:0] bp_read_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [BUF_BITS-1:0]   out_vc,
    input  logic                  credit_return,
    input  logic [BUF_BITS-1:0]   credit_vc,
    output logic                  timeout_err
);

    localparam logic [CREDIT_BITS:0] MAX_W = (CREDIT_BITS+1)'(MAX_CREDITS);

    logic [1:0]              state_q, state_d;
    logic [BUF_BITS-1:0]     grant_q, grant_d, rr_last_q, rr_last_d;
    logic                    rd_en_q, rd_en_d;
    logic [TIMEOUT_BITS-1:0] tmo_q, tmo_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic [BUF_BITS-1:0]     out_vc_q, out_vc_d;
    logic                    err_q, err_d;
    logic [CREDIT_BITS-1:0]  credit_q [NUM_VC];
    logic [CREDIT_BITS-1:0]  credit_d [NUM_VC];
    logic [CREDIT_BITS:0]    sum;
    logic [NUM_VC-1:0]       eligible, gnt_oh;
    logic [BUF_BITS-1:0]     gnt_idx;
    logic                    take, refund;

    always_comb begin
        eligible = '0;
        for (int v = 0; v < NUM_VC; v++)
            eligible[v] = enable & ~bp_empty[v] & (credit_q[v] != '0);
    end

    rr_arbiter #(.NUM_VC(NUM_VC), .IDX_W(BUF_BITS)) u_arb (
        .req_i     (eligible),
        .last_i    (rr_last_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_last_d   = rr_last_q;
        rd_en_d     = 1'b0;
        tmo_d       = tmo_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_vc_d    = out_vc_q;
        err_d       = err_q;
        take        = 1'b0;
        refund      = 1'b0;
        case (state_q)
            IDLE: if (|gnt_oh) begin
                state_d   = ISSUE;
                grant_d   = gnt_idx;
                rr_last_d = gnt_idx;
                rd_en_d   = 1'b1;
                take      = 1'b1;
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bp_valid && bp_out_vc == grant_q) begin
                out_data_d  = bp_read_data;
                out_vc_d    = grant_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end else begin
                tmo_d = tmo_q + TIMEOUT_BITS'(1);
                // Response never came: give the slot back so the VC is not starved forever.
                if (&tmo_d) begin
                    err_d   = 1'b1;
                    refund  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant and refund never coincide (different states); returns may overlap either.
    always_comb begin
        sum = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            sum = {1'b0, credit_q[v]}
                + (CREDIT_BITS+1)'(credit_return && credit_vc == BUF_BITS'(v))
                + (CREDIT_BITS+1)'(refund && grant_q == BUF_BITS'(v))
                - (CREDIT_BITS+1)'(take && gnt_idx == BUF_BITS'(v));
            credit_d[v] = (sum > MAX_W) ? MAX_W[CREDIT_BITS-1:0] : sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_last_q   <= BUF_BITS'(NUM_VC - 1);
            rd_en_q     <= 1'b0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_vc_q    <= '0;
            err_q       <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CREDIT_BITS'(MAX_CREDITS);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_last_q   <= rr_last_d;
            rd_en_q     <= rd_en_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_vc_q    <= out_vc_d;
            err_q       <= err_d;
            for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
        end
    end

    assign bp_rdEn     = rd_en_q;
    assign bp_read_vc  = grant_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_vc      = out_vc_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_vc_read_scheduler.sv
// Bench for vc_read_scheduler: transaction-level reference model plus directed scenarios with literal expectations.
module tb_vc_read_scheduler;

    localparam int DW = 32, BB = 1, NV = 2, CB = 3, MAXC = 4, TB = 4;
    localparam int TMO_AGE = 1 << TB;
    localparam int R_NORMAL = 0, R_NEVER = 1, R_WRONG = 2;
    typedef logic [BB-1:0] vc_t;

    logic          clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic [NV-1:0] bp_empty = '1;
    logic          bp_rdEn;
    vc_t           bp_read_vc;
    logic          bp_valid = 1'b0;
    vc_t           bp_out_vc = '0;
    logic [DW-1:0] bp_read_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    vc_t           out_vc;
    logic          credit_return = 1'b0;
    vc_t           credit_vc = '0;
    logic          timeout_err;

    vc_read_scheduler #(
        .DATA_WIDTH(DW), .BUF_BITS(BB), .CREDIT_BITS(CB), .MAX_CREDITS(MAXC), .TIMEOUT_BITS(TB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bp_empty(bp_empty),
        .bp_rdEn(bp_rdEn), .bp_read_vc(bp_read_vc), .bp_valid(bp_valid),
        .bp_out_vc(bp_out_vc), .bp_read_data(bp_read_data), .out_valid(out_valid),
        .out_data(out_data), .out_vc(out_vc), .credit_return(credit_return),
        .credit_vc(credit_vc), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Responder: answers a dequeue two cycles after bp_rdEn; data = D000_<vc>_<seq>.
    int        rsp_mode = R_NORMAL;
    int        rsp_cnt = 0;
    vc_t       rsp_vc = '0;
    bit        rsp_wrong_done = 1'b0;
    logic [7:0] rsp_seq = '0;
    vc_t       rsp_tag;
    always @(posedge clk) begin
        #1;
        bp_valid = 1'b0;
        if (!reset) begin
            rsp_cnt = 0;
            rsp_seq = '0;
        end else begin
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_tag = rsp_vc;
                    if (rsp_mode == R_WRONG && !rsp_wrong_done) begin
                        rsp_tag        = ~rsp_vc;
                        rsp_wrong_done = 1'b1;
                        rsp_cnt        = 1;
                    end
                    bp_valid     = 1'b1;
                    bp_out_vc    = rsp_tag;
                    bp_read_data = {16'hD000, 7'h00, rsp_tag, rsp_seq};
                    rsp_seq++;
                end
            end
            if (bp_rdEn && rsp_mode != R_NEVER) begin
                rsp_cnt        = 2;
                rsp_vc         = bp_read_vc;
                rsp_wrong_done = 1'b0;
            end
        end
    end

    // Reference model: one read outstanding, aged in cycles since its grant.
    int            m_cred [NV];
    vc_t           m_rr, m_vc, m_c, m_w;
    bit            m_busy, m_err, m_won, m_ref;
    int            m_age;
    bit            e_rden, e_ov;
    vc_t           e_rvc, e_ovc;
    logic [DW-1:0] e_od;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NV; v++) m_cred[v] = MAXC;
            m_rr = vc_t'(NV - 1); m_busy = 0; m_age = 0; m_vc = '0; m_err = 0;
            e_rden = 0; e_ov = 0; e_rvc = '0; e_ovc = '0; e_od = '0;
        end else begin
            e_rden = 0; e_ov = 0; m_ref = 0;
            if (!m_busy) begin
                m_won = 0;
                m_w   = '0;
                for (int i = 1; i <= NV; i++) begin
                    m_c = m_rr + vc_t'(i);
                    if (!m_won && enable && !bp_empty[m_c] && m_cred[m_c] > 0) begin
                        m_won = 1; m_w = m_c;
                    end
                end
                if (m_won) begin
                    m_busy = 1; m_age = 0; m_vc = m_w; m_rr = m_w;
                    m_cred[m_w]--; e_rden = 1; e_rvc = m_w;
                end
            end else begin
                m_age++;
                if (m_age >= 2 && bp_valid && bp_out_vc == m_vc) begin
                    e_ov = 1; e_od = bp_read_data; e_ovc = m_vc; m_busy = 0;
                end else if (m_age == TMO_AGE) begin
                    m_err = 1; m_ref = 1; m_busy = 0;
                end
            end
            if (m_ref) m_cred[m_vc]++;
            if (credit_return) m_cred[credit_vc]++;
            for (int v = 0; v < NV; v++) if (m_cred[v] > MAXC) m_cred[v] = MAXC;
        end
    end

    // Compare process and event bookkeeping.
    int rd_cnt [NV] = '{default: 0};
    int rd_total = 0, ov_total = 0, ov_cyc_last = 0;
    int gq[$];
    always @(negedge clk) begin
        if (reset) begin
            chk("cyc_rdEn",     bp_rdEn,     e_rden);
            chk("cyc_read_vc",  bp_read_vc,  e_rvc);
            chk("cyc_out_vld",  out_valid,   e_ov);
            chk("cyc_out_vc",   out_vc,      e_ovc);
            chk("cyc_out_data", out_data,    e_od);
            chk("cyc_tmo_err",  timeout_err, m_err);
            if (bp_rdEn) begin
                rd_cnt[bp_read_vc]++; rd_total++; gq.push_back(int'(bp_read_vc));
            end
            if (out_valid) begin
                ov_total++; ov_cyc_last = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apply_reset();
        reset = 1'b0; credit_return = 1'b0;
        step(3);
        reset = 1'b1;
    endtask

    task automatic wait_rd(input int budget, output int at_cyc);
        int k = 0;
        while (!bp_rdEn && k < budget) begin step(1); k++; end
        chk("wait_rdEn_bound", bp_rdEn, 1);
        at_cyc = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rel, t_rd, t_err, b_rd, b_ov, b_q, b_vc1, n, k;

        // Reset state, then a single VC0 transfer and its latency from release.
        enable = 1'b1; bp_empty = 2'b10; rsp_mode = R_NORMAL;
        step(2);
        chk("rst_rdEn", bp_rdEn, 0);
        chk("rst_read_vc", bp_read_vc, 0);
        chk("rst_out_vld", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_vc", out_vc, 0);
        chk("rst_tmo_err", timeout_err, 0);
        reset = 1'b1; rel = cyc; b_rd = rd_total; b_ov = ov_total;
        wait_rd(10, t_rd);
        chk("t1_rd_latency", t_rd - rel, 1);
        bp_empty = 2'b11;
        step(8);
        chk("t1_ov_latency", ov_cyc_last - rel, 4);
        chk("t1_ov_count", ov_total - b_ov, 1);
        chk("t1_out_vc", out_vc, 0);
        chk("t1_out_data", out_data, 32'hD000_0000);
        bp_empty = 2'b10;
        step(40);
        chk("t1_vc0_credit_left", rd_total - b_rd, 4);

        // Both VCs busy, no returns: alternate until credits run out.
        bp_empty = 2'b00;
        apply_reset();
        b_rd = rd_total; b_ov = ov_total; b_q = gq.size();
        step(60);
        chk("t2_grants", rd_total - b_rd, 8);
        chk("t2_out_valids", ov_total - b_ov, 8);
        for (int i = 0; i < 8; i++) chk("t2_order", gq[b_q + i], i % 2);

        // Credit return overlapping a VC1 grant decision.
        bp_empty = 2'b01;
        apply_reset();
        b_vc1 = rd_cnt[1]; n = 0; k = 0;
        while (n < 3 && k < 80) begin
            step(1); k++;
            if (out_valid) n++;
        end
        chk("t3_wait_bound", n, 3);
        credit_return = 1'b1; credit_vc = 1'b1;
        step(1);
        credit_return = 1'b0;
        chk("t3_regrant", bp_rdEn, 1);
        step(40);
        chk("t3_vc1_grants", rd_cnt[1] - b_vc1, 5);

        // Responder silent: timeout, refund, and normal service afterwards.
        bp_empty = 2'b10; rsp_mode = R_NEVER;
        apply_reset();
        b_rd = rd_total; b_ov = ov_total;
        wait_rd(10, t_rd);
        k = 0;
        while (!timeout_err && k < 40) begin step(1); k++; end
        chk("t4_err_bound", timeout_err, 1);
        t_err = cyc;
        rsp_mode = R_NORMAL;
        chk("t4_err_latency", t_err - t_rd, 16);
        step(50);
        chk("t4_grants", rd_total - b_rd, 5);
        chk("t4_out_valids", ov_total - b_ov, 4);
        chk("t4_err_sticky", timeout_err, 1);

        // Mismatched VC response is ignored; the matching one is forwarded.
        bp_empty = 2'b10; rsp_mode = R_WRONG;
        apply_reset();
        b_rd = rd_total; b_ov = ov_total;
        wait_rd(10, t_rd);
        bp_empty = 2'b11;
        step(20);
        chk("t5_out_valids", ov_total - b_ov, 1);
        chk("t5_grants", rd_total - b_rd, 1);
        chk("t5_out_data", out_data, 32'hD000_0001);
        chk("t5_out_vc", out_vc, 0);

        // enable low blocks grants; async reset during WAIT.
        enable = 1'b0; bp_empty = 2'b00; rsp_mode = R_NORMAL;
        apply_reset();
        b_rd = rd_total;
        step(20);
        chk("t6_disabled", rd_total - b_rd, 0);
        bp_empty = 2'b01; rsp_mode = R_NEVER; enable = 1'b1;
        wait_rd(10, t_rd);
        step(3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_arst_rdEn", bp_rdEn, 0);
        chk("t6_arst_read_vc", bp_read_vc, 0);
        chk("t6_arst_out_vld", out_valid, 0);
        chk("t6_arst_tmo_err", timeout_err, 0);
        chk("t6_arst_out_data", out_data, 0);
        chk("t6_arst_out_vc", out_vc, 0);
        bp_empty = 2'b11; rsp_mode = R_NORMAL;
        step(2);
        reset = 1'b1;
        b_rd = rd_total; b_ov = ov_total;
        step(15);
        chk("t6_quiet_out_valids", ov_total - b_ov, 0);
        chk("t6_quiet_grants", rd_total - b_rd, 0);
        bp_empty = 2'b01;
        step(40);
        chk("t6_restored_grants", rd_total - b_rd, 4);
        chk("t6_restored_out_valids", ov_total - b_ov, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vc_read_scheduler.md
Name: vc_read_scheduler

Overview:
- Read-side controller for one buffer_port instance (NUM_VC virtual-channel FIFOs).
- Selects a non-empty VC that has downstream credit, issues a single-cycle dequeue, waits for the matching response, and forwards the flit with its VC tag.
- Keeps one read outstanding so that lagging empty flags can never cause over-dequeue.
- Sits between buffer_port and the switch/link stage; it consumes credit returns from that stage.

Parameters:
- DATA_WIDTH, 32, flit width; matches buffer_port.
- BUF_BITS, 1, VC index width; NUM_VC = 1 << BUF_BITS.
- CREDIT_BITS, 3, width of each per-VC credit counter.
- MAX_CREDITS, 4, reset and saturation value of each credit counter; must be <= 2^CREDIT_BITS - 1.
- TIMEOUT_BITS, 4, width of the response-wait counter; timeout occurs after 2^TIMEOUT_BITS - 1 cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  0 = issue no new grants; an in-flight read still completes.
- bp_empty  in  NUM_VC  per-VC empty flags from buffer_port.
- bp_rdEn  out  1  dequeue request to buffer_port.
- bp_read_vc  out  BUF_BITS  VC to dequeue; held stable until the next grant.
- bp_valid  in  1  buffer_port response valid.
- bp_out_vc  in  BUF_BITS  VC of the buffer_port response.
- bp_read_data  in  DATA_WIDTH  buffer_port response data.
- out_valid  out  1  one-cycle pulse marking a forwarded flit.
- out_data  out  DATA_WIDTH  forwarded flit; held until the next out_valid.
- out_vc  out  BUF_BITS  VC of the forwarded flit.
- credit_return  in  1  downstream freed one slot.
- credit_vc  in  BUF_BITS  VC of the returned credit.
- timeout_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all outputs 0; bp_read_vc = 0.
  - credit[v] = MAX_CREDITS for every VC.
  - rr_last = NUM_VC-1, so VC0 has first priority.
- Eligibility: eligible[v] = enable & ~bp_empty[v] & (credit[v] != 0).
- Arbitration: round-robin. Search starts at rr_last+1 and wraps modulo NUM_VC; the first eligible VC wins.
- States:
  - IDLE: if any VC is eligible, latch grant = winner, set rr_last = winner, set bp_read_vc = winner, decrement credit[winner], assert bp_rdEn (registered), go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly one cycle): deassert bp_rdEn, clear the timeout counter, go to WAIT. bp_rdEn is high for exactly one cycle per grant, which produces exactly one pop.
  - WAIT, response: if bp_valid & (bp_out_vc == grant), register out_data = bp_read_data and out_vc = grant, pulse out_valid next cycle, go to IDLE. A bp_valid with a mismatching VC is ignored.
  - WAIT, timeout: else increment the counter. On reaching all-ones, set timeout_err, refund credit[grant] (+1), go to IDLE with no out_valid.
- Latency: eligibility sampled in cycle t -> bp_rdEn high in t+1 -> earliest bp_valid sampled in t+3 -> out_valid in t+4. Maximum throughput is one flit per 4 cycles plus the FIFO response latency.
- Credits: credit_return increments credit[credit_vc], saturating at MAX_CREDITS; returns beyond that are dropped silently.
  - Simultaneous grant decrement and return on the same VC: net no change.
  - Timeout refund and credit_return on the same VC in the same cycle: +2, saturating.
- bp_empty changes during ISSUE/WAIT are ignored; eligibility is evaluated only in IDLE.
- Reset asserted mid-operation: immediate return to reset values. The dropped in-flight flit is not reported.
- Arithmetic: credit counters are unsigned CREDIT_BITS; no wrap below 0, because a zero-credit VC is never eligible.

Decomposition:
- Shared package vc_pkg holds:
  - the state encoding, localparam IDLE/ISSUE/WAIT;
  - NUM_VC derivation from BUF_BITS;
  - credit/VC width constants reused by buffer_port users.
- One natural sub-module: rr_arbiter (parameter NUM_VC). Inputs are the request vector and rr_last; outputs are a grant one-hot and index, combinational. It is reusable by the switch allocator.

Test Plan:
- Reset release; bp_empty=2'b10, responder returns bp_valid/out_vc=0 two cycles after bp_rdEn -> one bp_rdEn pulse with bp_read_vc=0; out_valid 4 cycles after release+1 with out_vc=0 and matching data; credit[0]=3.
- Both VCs non-empty continuously, MAX_CREDITS=4, no credit returns -> grant order 0,1,0,1,0,1,0,1, then no further bp_rdEn; exactly 8 out_valid pulses.
- VC1 credits exhausted, then credit_return with credit_vc=1 in the same cycle as a VC1 grant decision -> VC1 re-granted next IDLE; the counter ends unchanged by the overlap.
- Responder never asserts bp_valid -> timeout_err rises after 15 WAIT cycles; credit refunded (back to 4); state IDLE; next grant proceeds normally; timeout_err stays 1.
- Responder returns bp_valid with bp_out_vc != grant, then the correct VC one cycle later -> only the matching response is forwarded; one out_valid.
- enable=0 with non-empty VCs -> no bp_rdEn. reset pulled low during WAIT -> outputs 0 asynchronously, credits restored to 4, no out_valid after release until a new grant.
